// File: rtl/midi_transmitter.sv
// MIDI 8N1 serial transmitter: accepts status/data1/data2 messages and shifts them out LSB first.
// Optional build macro RUNNING_STATUS_EN suppresses repeated channel status bytes (MIDI running status).
module midi_transmitter #(
  parameter int CLKS_PER_BIT = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] status,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic       two_byte,
  output logic       midi_out,
  output logic       busy,
  output logic       err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       status_q, status_d;
  logic [7:0]       data1_q, data1_d;
  logic [7:0]       data2_q, data2_d;
  logic             err_q, err_d;

  logic       accept;
  logic       legal;
  logic       bit_end;
  logic       last_byte;
  logic       skip_status;
  logic [7:0] cur_byte;

  assign accept    = msg_valid && (state_q == IDLE);
  assign legal     = status[7];
  assign bit_end   = (tick_q == LAST_TICK);
  assign last_byte = (byte_q == last_q);

`ifdef RUNNING_STATUS_EN
  logic [7:0] rs_q, rs_d;

  // rs_q only ever holds 0x00 or a channel status, so a legal status can match it only when repeated.
  assign skip_status = legal && (status == rs_q);

  always_comb begin
    rs_d = rs_q;
    if (accept && legal) begin
      rs_d = (status >= 8'hF0) ? 8'h00 : status;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rs_q <= 8'h00;
    else     rs_q <= rs_d;
  end
`else
  assign skip_status = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && legal)           state_d = START;
      START:   if (bit_end)                   state_d = DATA;
      DATA:    if (bit_end && bit_q == 3'd7)  state_d = STOP;
      STOP:    if (bit_end)                   state_d = last_byte ? IDLE : START;
      default:                                state_d = IDLE;
    endcase
  end

  // Datapath next-state: bit timing, byte sequencing and message capture
  always_comb begin
    tick_d   = (state_q == IDLE || bit_end) ? '0 : tick_q + 1'b1;
    bit_d    = (state_q == DATA && bit_end) ? bit_q + 3'd1 : bit_q;
    byte_d   = byte_q;
    last_d   = last_q;
    status_d = status_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    err_d    = 1'b0;

    if (accept) begin
      err_d = ~legal;
      if (legal) begin
        status_d = status;
        data1_d  = data1;
        data2_d  = data2;
        byte_d   = skip_status ? 2'd1 : 2'd0;
        last_d   = two_byte ? 2'd1 : 2'd2;
      end
    end else if (state_q == STOP && bit_end && !last_byte) begin
      byte_d = byte_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q   <= '0;
      bit_q    <= 3'd0;
      byte_q   <= 2'd0;
      last_q   <= 2'd0;
      status_q <= 8'h00;
      data1_q  <= 8'h00;
      data2_q  <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
      status_q <= status_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      err_q    <= err_d;
    end
  end

  // Output logic
  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = status_q;
      2'd1:    cur_byte = data1_q;
      default: cur_byte = data2_q;
    endcase

    midi_out  = 1'b1;
    msg_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    err       = err_q;
    case (state_q)
      START:   midi_out = 1'b0;
      DATA:    midi_out = cur_byte[bit_q];
      default: midi_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_midi_transmitter.sv
// Self-checking bench for midi_transmitter: scoreboard of expected bytes, serial-line frame monitor.
// Define RUNNING_STATUS_EN for both bench and RTL to exercise running status.
module tb_midi_transmitter;

  localparam int CPB = 128;
`ifdef RUNNING_STATUS_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       msg_valid = 1'b0;
  logic       two_byte = 1'b0;
  logic [7:0] status = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic [7:0] data2 = 8'h00;
  logic       msg_ready;
  logic       midi_out;
  logic       busy;
  logic       err;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         frames_seen = 0;
  logic [7:0] rs_model = 8'h00;
  int         cur_nbytes = 0;
  int         cur_f0 = 0;

  logic [9:0] mon_obs;
  logic [9:0] mon_exp;
  logic [7:0] mon_eb;
  int         mon_bad;
  bit         mon_abort;

  always #5 clk = ~clk;

  midi_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .status   (status),
    .data1    (data1),
    .data2    (data2),
    .two_byte (two_byte),
    .midi_out (midi_out),
    .busy     (busy),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame monitor: samples every cycle of a frame, pops the expected byte when a full frame is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && midi_out === 1'b0) begin
        mon_eb    = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        mon_exp   = {1'b1, mon_eb, 1'b0};
        mon_obs   = '0;
        mon_bad   = 0;
        mon_abort = 1'b0;
        for (int i = 0; i < 10 * CPB; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            mon_abort = 1'b1;
            break;
          end
          if (i % CPB == CPB / 2) mon_obs[i / CPB] = midi_out;
          if (midi_out !== mon_exp[i / CPB]) mon_bad++;
        end
        if (!mon_abort) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", exp_q.size(), 1);
          end else begin
            void'(exp_q.pop_front());
            check("frame_bits", mon_obs, mon_exp);
            check("frame_bad_samples", mon_bad, 0);
          end
          frames_seen++;
        end
      end
    end
  end

  task automatic offer(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                       input logic tb);
    int wait_n = 0;
    while (!msg_ready && wait_n < 40 * CPB) begin
      @(negedge clk);
      wait_n++;
    end
    check("ready_before_offer", msg_ready, 1);
    status   = st;
    data1    = d1;
    data2    = d2;
    two_byte = tb;
    cur_nbytes = 0;
    if (st[7]) begin
      if (!(RS_EN && st == rs_model)) begin
        exp_q.push_back(st);
        cur_nbytes++;
      end
      exp_q.push_back(d1);
      cur_nbytes++;
      if (!tb) begin
        exp_q.push_back(d2);
        cur_nbytes++;
      end
      if (RS_EN) rs_model = (st >= 8'hF0) ? 8'h00 : st;
    end
    cur_f0    = frames_seen;
    msg_valid = 1'b1;
    @(posedge clk);
    #1;
    if (st[7]) begin
      check("start_low", midi_out, 0);
      check("busy_on", busy, 1);
      check("ready_off", msg_ready, 0);
      check("err_quiet", err, 0);
    end else begin
      check("err_pulse", err, 1);
      check("illegal_busy_low", busy, 0);
      check("illegal_line_high", midi_out, 1);
      check("illegal_ready_high", msg_ready, 1);
    end
  endtask

  // Waits out the transmission; with hold set, msg_valid stays high while inputs churn.
  task automatic finish_msg(input bit hold);
    int  n = 0;
    bit  done = 1'b0;
    for (int i = 0; i < cur_nbytes * 10 * CPB + 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      n++;
      if (hold) begin
        status   = 8'($urandom_range(8'h80, 8'hEF));
        data1    = 8'($urandom_range(0, 255));
        data2    = 8'($urandom_range(0, 255));
        two_byte = 1'($urandom_range(0, 1));
      end else begin
        msg_valid = 1'b0;
      end
    end
    check("busy_done", done, 1);
    check("busy_cycles", n, cur_nbytes * 10 * CPB);
    check("ready_back", msg_ready, 1);
    check("frame_count", frames_seen - cur_f0, cur_nbytes);
  endtask

  initial begin
    #(100_000 * 10);
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int errs;
    int busys;
    int lows;

    #1 rst = 1'b1;
    #2;
    check("rst_line_high", midi_out, 1);
    check("rst_ready", msg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Note-on, full three-byte message
    offer(8'h90, 8'h3C, 8'h64, 1'b0);
    finish_msg(1'b0);

    // Program change, two-byte message
    offer(8'hC0, 8'h05, 8'hAA, 1'b1);
    finish_msg(1'b0);

    // Running-status sequence (all bytes sent when the feature is off)
    offer(8'h90, 8'h3C, 8'h64, 1'b0);
    finish_msg(1'b0);
    offer(8'h90, 8'h40, 8'h00, 1'b0);
    finish_msg(1'b0);
    offer(8'hF8, 8'h00, 8'h00, 1'b1);
    finish_msg(1'b0);
    offer(8'h90, 8'h3C, 8'h64, 1'b0);
    finish_msg(1'b0);

    // Illegal status byte
    offer(8'h3C, 8'h11, 8'h22, 1'b0);
    errs = 0;
    busys = 0;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      msg_valid = 1'b0;
      if (err) errs++;
      if (busy) busys++;
      if (!midi_out) lows++;
    end
    check("illegal_err_cycles", errs, 1);
    check("illegal_busy_cycles", busys, 0);
    check("illegal_line_low_cycles", lows, 0);

    // msg_valid held with churning inputs; the next message lands only in IDLE
    offer(8'hB0, 8'h07, 8'h7F, 1'b0);
    finish_msg(1'b1);
    offer(8'hE0, 8'h12, 8'h34, 1'b1);
    finish_msg(1'b0);

    // Asynchronous reset in the middle of a frame
    offer(8'h90, 8'h3C, 8'h64, 1'b0);
    for (int i = 0; i < 699; i++) begin
      @(negedge clk);
      msg_valid = 1'b0;
    end
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_line_high", midi_out, 1);
    check("async_rst_ready", msg_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_err", err, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rs_model = 8'h00;
    rst = 1'b0;
    offer(8'h90, 8'h40, 8'h7F, 1'b0);
    finish_msg(1'b0);

    repeat (20) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
